// File: rtl/pio_out_pulse.sv
// Avalon-MM output port with atomic SET/CLEAR/TOGGLE writes and a hardware-timed
// pulse mode that forces selected bits high for pulse_len cycles.
module pio_out_pulse #(
  parameter int                    DATA_WIDTH      = 8,
  parameter int                    CNT_WIDTH       = 24,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
  parameter logic [CNT_WIDTH-1:0]  PULSE_LEN_RESET = CNT_WIDTH'(1000)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  pulse_busy
);

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_SET       = 3'd1;
  localparam logic [2:0] ADDR_CLEAR     = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE    = 3'd3;
  localparam logic [2:0] ADDR_PULSE     = 3'd4;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd5;
  localparam logic [2:0] ADDR_STATUS    = 3'd6;

  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic [DATA_WIDTH-1:0] pulse_mask_reg, pulse_mask_next;
  logic [CNT_WIDTH-1:0]  pulse_len_reg, pulse_len_next;
  logic [CNT_WIDTH-1:0]  pulse_cnt_reg, pulse_cnt_next;

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd;
  logic                  pulse_wr;
  logic                  pulse_abort;
  logic                  pulse_load;
  logic [CNT_WIDTH:0]    status_word;
  logic                  unused_wd;

  assign wr          = chipselect & ~write_n;
  assign wd          = writedata[DATA_WIDTH-1:0];
  assign unused_wd   = ^writedata;
  assign pulse_wr    = wr && (address == ADDR_PULSE);
  assign pulse_abort = pulse_wr && (wd == '0);
  // A nonzero PULSE write with a zero length is dropped; the counter keeps running.
  assign pulse_load  = pulse_wr && (wd != '0) && (pulse_len_reg != '0);

  always_comb begin
    data_next      = data_reg;
    pulse_len_next = pulse_len_reg;
    if (wr) begin
      case (address)
        ADDR_DATA:      data_next      = wd;
        ADDR_SET:       data_next      = data_reg | wd;
        ADDR_CLEAR:     data_next      = data_reg & ~wd;
        ADDR_TOGGLE:    data_next      = data_reg ^ wd;
        ADDR_PULSE_LEN: pulse_len_next = writedata[CNT_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Reload wins over expiry so a retrigger on the last cycle merges with the old mask.
  always_comb begin
    pulse_mask_next = pulse_mask_reg;
    pulse_cnt_next  = pulse_cnt_reg;
    if (pulse_abort) begin
      pulse_mask_next = '0;
      pulse_cnt_next  = '0;
    end else if (pulse_load) begin
      pulse_mask_next = pulse_mask_reg | wd;
      pulse_cnt_next  = pulse_len_reg;
    end else if (pulse_cnt_reg != '0) begin
      pulse_cnt_next = pulse_cnt_reg - 1'b1;
      if (pulse_cnt_reg == CNT_WIDTH'(1)) begin
        pulse_mask_next = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg       <= RESET_VALUE;
      pulse_len_reg  <= PULSE_LEN_RESET;
      pulse_mask_reg <= '0;
      pulse_cnt_reg  <= '0;
    end else begin
      data_reg       <= data_next;
      pulse_len_reg  <= pulse_len_next;
      pulse_mask_reg <= pulse_mask_next;
      pulse_cnt_reg  <= pulse_cnt_next;
    end
  end

  assign pulse_busy  = (pulse_cnt_reg != '0);
  assign status_word = {pulse_cnt_reg, pulse_busy};

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata = 32'(data_reg);
      ADDR_PULSE:     readdata = 32'(pulse_mask_reg);
      ADDR_PULSE_LEN: readdata = 32'(pulse_len_reg);
      ADDR_STATUS:    readdata = 32'(status_word);
      default:        readdata = '0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_out
      assign out_port[gi] = data_reg[gi] | pulse_mask_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_pio_out_pulse.sv
// Bench for pio_out_pulse: directed vector table, hand-written reset sequences and
// random traffic checked against an expiry-time model of the pulse engine.
module tb_pio_out_pulse;

  localparam int         DW = 8;
  localparam int         CW = 24;
  localparam logic [7:0] RV = 8'h5A;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    address = 3'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;
  logic          pulse_busy;

  pio_out_pulse #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH(CW),
    .RESET_VALUE(RV),
    .PULSE_LEN_RESET(24'd1000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .pulse_busy(pulse_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Model: a pulse is described by the edge number on which it ends, not by a counter.
  int          edge_no = 0;
  int          m_end   = 0;
  logic [7:0]  m_data  = RV;
  logic [7:0]  m_mask  = '0;
  int unsigned m_len   = 1000;

  function automatic bit m_busy();
    return m_end > edge_no;
  endfunction

  function automatic logic [7:0] m_out();
    return m_data | (m_busy() ? m_mask : 8'h00);
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    int rem;
    rem = m_busy() ? (m_end - edge_no) : 0;
    case (a)
      3'd0:    return {24'h0, m_data};
      3'd4:    return {24'h0, (m_busy() ? m_mask : 8'h00)};
      3'd5:    return m_len;
      3'd6:    return (rem * 2) + (m_busy() ? 1 : 0);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_data = RV;
    m_len  = 1000;
    m_mask = '0;
    m_end  = 0;
  endtask

  task automatic model_step(input bit wr, input logic [2:0] a, input logic [31:0] wd);
    logic [7:0] w8;
    bit         live;
    edge_no++;
    w8   = wd[7:0];
    live = (m_end >= edge_no);
    if (wr) begin
      case (a)
        3'd0: m_data = w8;
        3'd1: m_data = m_data | w8;
        3'd2: m_data = m_data & ~w8;
        3'd3: m_data = m_data ^ w8;
        3'd4: begin
          if (w8 == 8'h00) begin
            m_mask = '0;
            m_end  = 0;
          end else if (m_len != 0) begin
            m_mask = (live ? m_mask : 8'h00) | w8;
            m_end  = edge_no + int'(m_len);
          end
        end
        3'd5: m_len = wd & 32'h00FF_FFFF;
        default: ;
      endcase
    end
  endtask

  task automatic tick(input bit wr, input logic [2:0] a, input logic [31:0] wd);
    @(negedge clk);
    address   = a;
    writedata = wd;
    if (wr) begin
      chipselect = 1'b1;
      write_n    = 1'b0;
    end else begin
      case ($urandom_range(0, 2))
        0:       begin chipselect = 1'b0; write_n = 1'b0; end
        1:       begin chipselect = 1'b1; write_n = 1'b1; end
        default: begin chipselect = 1'b0; write_n = 1'b1; end
      endcase
    end
    @(posedge clk);
    model_step(wr, a, wd);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out"},  32'(out_port),   32'(m_out()));
    check({tag, ".busy"}, 32'(pulse_busy), 32'(m_busy()));
    check({tag, ".rd"},   readdata,        m_read(address));
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [7:0]  exp_out;
    bit          exp_busy;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit wr, input logic [2:0] a, input logic [31:0] wd,
                              input logic [7:0] eo, input bit eb, input logic [31:0] er);
    vec_t v;
    v.wr = wr; v.addr = a; v.wd = wd; v.exp_out = eo; v.exp_busy = eb; v.exp_rd = er;
    tbl.push_back(v);
  endfunction

  initial begin
    // atomic ops
    add(1, 0, 32'h0F, 8'h0F, 0, 32'h0F);
    add(1, 1, 32'hF0, 8'hFF, 0, 32'h00);
    add(1, 2, 32'h03, 8'hFC, 0, 32'h00);
    add(1, 3, 32'h81, 8'h7D, 0, 32'h00);
    add(0, 0, 32'h00, 8'h7D, 0, 32'h7D);
    // pulse timing: 4 cycles high, STATUS counts down
    add(1, 5, 32'h04, 8'h7D, 0, 32'h04);
    add(1, 0, 32'h00, 8'h00, 0, 32'h00);
    add(1, 4, 32'h80, 8'h80, 1, 32'h80);
    add(0, 6, 32'h00, 8'h80, 1, 32'h07);
    add(0, 6, 32'h00, 8'h80, 1, 32'h05);
    add(0, 6, 32'h00, 8'h80, 1, 32'h03);
    add(0, 6, 32'h00, 8'h00, 0, 32'h00);
    // retrigger on the expiry edge merges masks
    add(1, 5, 32'h03, 8'h00, 0, 32'h03);
    add(1, 4, 32'h01, 8'h01, 1, 32'h01);
    add(0, 6, 32'h00, 8'h01, 1, 32'h05);
    add(0, 6, 32'h00, 8'h01, 1, 32'h03);
    add(1, 4, 32'h02, 8'h03, 1, 32'h03);
    add(0, 6, 32'h00, 8'h03, 1, 32'h05);
    add(0, 6, 32'h00, 8'h03, 1, 32'h03);
    add(0, 6, 32'h00, 8'h00, 0, 32'h00);
    // abort after 2 cycles
    add(1, 5, 32'h0A, 8'h00, 0, 32'h0A);
    add(1, 0, 32'h11, 8'h11, 0, 32'h11);
    add(1, 4, 32'h40, 8'h51, 1, 32'h40);
    add(0, 6, 32'h00, 8'h51, 1, 32'h13);
    add(1, 4, 32'h00, 8'h11, 0, 32'h00);
    add(0, 6, 32'h00, 8'h11, 0, 32'h00);
    // zero length pulse is ignored
    add(1, 5, 32'h00, 8'h11, 0, 32'h00);
    add(1, 4, 32'hFF, 8'h11, 0, 32'h00);
    add(0, 6, 32'h00, 8'h11, 0, 32'h00);
    // data write during a pulse touches only data_reg
    add(1, 5, 32'h02, 8'h11, 0, 32'h02);
    add(1, 4, 32'h0C, 8'h1D, 1, 32'h0C);
    add(1, 2, 32'h11, 8'h0C, 1, 32'h00);
    add(0, 6, 32'h00, 8'h00, 0, 32'h00);
    // reserved address and truncation of wide writedata
    add(1, 7, 32'hFF, 8'h00, 0, 32'h00);
    add(1, 0, 32'hFFFF_FFA5, 8'hA5, 0, 32'hA5);
    add(1, 5, 32'hFF00_0005, 8'hA5, 0, 32'h05);
  end

  initial begin
    // power-on reset, then release
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    address = 3'd5;
    #1;
    check("por.out",    32'(out_port),   32'(RV));
    check("por.busy",   32'(pulse_busy), 32'h0);
    check("por.len_rd", readdata,        32'd1000);

    tick(1, 0, 32'h33);
    check("pre_rst.out", 32'(out_port), 32'h33);

    // asynchronous reset between edges
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check("arst.out",  32'(out_port),   32'(RV));
    check("arst.busy", 32'(pulse_busy), 32'h0);
    address = 3'd5;
    #1;
    check("arst.len_rd", readdata, 32'd1000);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      tick(tbl[i].wr, tbl[i].addr, tbl[i].wd);
      $display("vec %0d wr=%0b a=%0d wd=%08h out=%02h busy=%0b rd=%08h",
               i, tbl[i].wr, tbl[i].addr, tbl[i].wd, out_port, pulse_busy, readdata);
      check($sformatf("vec%0d.out", i),  32'(out_port),   32'(tbl[i].exp_out));
      check($sformatf("vec%0d.busy", i), 32'(pulse_busy), 32'(tbl[i].exp_busy));
      check($sformatf("vec%0d.rd", i),   readdata,        tbl[i].exp_rd);
    end

    // reset in the middle of a 100-cycle pulse
    tick(1, 5, 32'd100);
    tick(1, 4, 32'h0F);
    check("mid.out", 32'(out_port), 32'hAF);
    repeat (50) tick(0, 6, 32'h0);
    check_model("mid.model");
    check("mid.status50", readdata, 32'd101);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("mid_rst.out",    32'(out_port),   32'(RV));
    check("mid_rst.busy",   32'(pulse_busy), 32'h0);
    check("mid_rst.status", readdata,        32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(0, 6, 32'h0);
      $display("post_rst %0d out=%02h busy=%0b rd=%08h", k, out_port, pulse_busy, readdata);
      check($sformatf("post_rst%0d.out", k), 32'(out_port), 32'(RV));
      check_model($sformatf("post_rst%0d", k));
    end

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      bit          wr;
      logic [2:0]  a;
      logic [31:0] wd;
      wr = ($urandom_range(0, 99) < 55);
      a  = 3'($urandom_range(0, 7));
      case (a)
        3'd4:    wd = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
        3'd5:    wd = $urandom_range(0, 8) | (($urandom_range(0, 3) == 0) ? 32'hFF00_0000 : 32'h0);
        default: wd = $urandom;
      endcase
      tick(wr, a, wd);
      $display("rnd %0d wr=%0b a=%0d wd=%08h out=%02h busy=%0b rd=%08h",
               n, wr, a, wd, out_port, pulse_busy, readdata);
      check_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
